// File: rtl/dft_sequencer_pkg.sv
// dft_sequencer_pkg: shared widths and state encoding for the direct-DFT sequencer.
package dft_sequencer_pkg;

    localparam int DEF_IDX_W  = 12;
    localparam int RD_LAT_MAX = 4;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t S_IDLE    = 3'd0;
    localparam seq_state_t S_LOAD    = 3'd1;
    localparam seq_state_t S_FLUSH_L = 3'd2;
    localparam seq_state_t S_COMPUTE = 3'd3;
    localparam seq_state_t S_FLUSH_C = 3'd4;
    localparam seq_state_t S_WRITE   = 3'd5;
    localparam seq_state_t S_DONE    = 3'd6;

endpackage

// File: rtl/dft_sequencer_idx_counter.sv
// dft_sequencer_idx_counter: wrapping index counter 0..max with synchronous clear.
module dft_sequencer_idx_counter
    import dft_sequencer_pkg::*;
#(
    parameter int W = DEF_IDX_W
) (
    input  logic         clk,
    input  logic         n_Reset,
    input  logic         ce_i,
    input  logic         clr_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] value_o,
    output logic         last_o
);

    logic [W-1:0] value_q, value_d;

    assign last_o  = value_q == max_i;
    assign value_o = value_q;
    assign value_d = clr_i ? '0 : !ce_i ? value_q : last_o ? '0 : value_q + 1'b1;

    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) value_q <= '0;
        else          value_q <= value_d;
    end

endmodule

// File: rtl/dft_sequencer.sv
// dft_sequencer: pipeline-aware scheduler for the DFT load, k/n sweep and per-bin write-back.
module dft_sequencer
    import dft_sequencer_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             n_Reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic             result_ack,
    input  logic [IDX_W-1:0] sample_num,
    output logic             load_nCompute,
    output logic             ram_rd,
    output logic             cache_we,
    output logic [IDX_W-1:0] cache_wadr,
    output logic [IDX_W-1:0] n_index,
    output logic [IDX_W-1:0] k_index,
    output logic             acc_ce,
    output logic             acc_clr,
    output logic             result_we,
    output logic             calc_end,
    output logic             busy,
    output logic [2:0]       state_o
);

    localparam int FL_W = $clog2(RD_LAT_MAX);

    seq_state_t                   state_q, state_d;
    logic [IDX_W-1:0]             max_q, max_d;
    logic [FL_W-1:0]              fcnt_q, fcnt_d;
    logic [RD_LAT-1:0]            ld_q, iss_q;
    logic [RD_LAT-1:0][IDX_W-1:0] adr_q;
    logic                         kill, go, issue, in_flush, f_done;
    logic                         n_last, k_last, idx_clr, k_ce;

    // Abort and loss of enable beat every other transition, including a pending start.
    assign kill     = (abort || !enable) && state_q != S_IDLE;
    assign go       = state_q == S_IDLE && enable && start && !abort && sample_num != '0;
    assign issue    = state_q == S_LOAD || state_q == S_COMPUTE;
    assign in_flush = state_q == S_FLUSH_L || state_q == S_FLUSH_C;
    assign f_done   = fcnt_q == FL_W'(RD_LAT - 1);
    assign idx_clr  = kill || (state_q == S_DONE && result_ack);
    assign k_ce     = state_q == S_WRITE && !k_last;
    assign max_d    = go ? sample_num - 1'b1 : max_q;
    assign fcnt_d   = (in_flush && !f_done && !kill) ? fcnt_q + 1'b1 : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = go ? S_LOAD : S_IDLE;
            S_LOAD:    state_d = n_last ? S_FLUSH_L : S_LOAD;
            S_FLUSH_L: state_d = f_done ? S_COMPUTE : S_FLUSH_L;
            S_COMPUTE: state_d = n_last ? S_FLUSH_C : S_COMPUTE;
            S_FLUSH_C: state_d = f_done ? S_WRITE : S_FLUSH_C;
            S_WRITE:   state_d = k_last ? S_DONE : S_COMPUTE;
            S_DONE:    state_d = result_ack ? S_IDLE : S_DONE;
            default:   state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    // Read-latency delay lines: newest entry at bit 0, tap at RD_LAT-1.
    always_ff @(posedge clk or negedge n_Reset) begin
        if (!n_Reset) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            fcnt_q  <= '0;
            ld_q    <= '0;
            iss_q   <= '0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            fcnt_q  <= fcnt_d;
            if (kill) begin
                ld_q  <= '0;
                iss_q <= '0;
                adr_q <= '0;
            end else begin
                ld_q  <= RD_LAT'({ld_q, state_q == S_LOAD});
                iss_q <= RD_LAT'({iss_q, state_q == S_COMPUTE});
                adr_q <= (RD_LAT * IDX_W)'({adr_q, n_index});
            end
        end
    end

    dft_sequencer_idx_counter #(.W(IDX_W)) u_n_cnt (
        .clk     (clk),
        .n_Reset (n_Reset),
        .ce_i    (issue),
        .clr_i   (idx_clr),
        .max_i   (max_q),
        .value_o (n_index),
        .last_o  (n_last)
    );

    dft_sequencer_idx_counter #(.W(IDX_W)) u_k_cnt (
        .clk     (clk),
        .n_Reset (n_Reset),
        .ce_i    (k_ce),
        .clr_i   (idx_clr),
        .max_i   (max_q),
        .value_o (k_index),
        .last_o  (k_last)
    );

    assign ram_rd        = state_q == S_LOAD;
    assign load_nCompute = !(state_q == S_COMPUTE || state_q == S_FLUSH_C || state_q == S_WRITE);
    assign cache_we      = ld_q[RD_LAT-1];
    assign cache_wadr    = adr_q[RD_LAT-1];
    assign acc_ce        = iss_q[RD_LAT-1];
    assign acc_clr       = state_q == S_WRITE || kill;
    assign result_we     = state_q == S_WRITE && !kill;
    assign calc_end      = state_q == S_DONE;
    assign busy          = state_q != S_IDLE && state_q != S_DONE;
    assign state_o       = state_q;

endmodule

// File: tb/tb_dft_sequencer.sv
// tb_dft_sequencer: two sequencers (RD_LAT 1 and 3) driven in lockstep and checked against a cycle-timeline model.
module tb_dft_sequencer;
    import dft_sequencer_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        lnc;
        logic        ram_rd;
        logic        cache_we;
        logic        acc_ce;
        logic        acc_clr;
        logic        result_we;
        logic        calc_end;
        logic [11:0] n_index;
        logic [11:0] k_index;
        logic [11:0] wadr;
        logic [2:0]  st;
    } obs_t;

    logic        clk = 0, n_Reset = 1, enable = 1, start = 0, abort = 0, result_ack = 0;
    logic [11:0] sample_num = '0;
    obs_t        obs [2];
    int          lat [2] = '{1, 3};
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        busy, lnc, ram_rd, cache_we, acc_ce, acc_clr, result_we, calc_end;
        logic [11:0] n_index, k_index, cache_wadr;
        logic [2:0]  state_o;
        dft_sequencer #(.IDX_W(12), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk           (clk),
            .n_Reset       (n_Reset),
            .enable        (enable),
            .start         (start),
            .abort         (abort),
            .result_ack    (result_ack),
            .sample_num    (sample_num),
            .load_nCompute (lnc),
            .ram_rd        (ram_rd),
            .cache_we      (cache_we),
            .cache_wadr    (cache_wadr),
            .n_index       (n_index),
            .k_index       (k_index),
            .acc_ce        (acc_ce),
            .acc_clr       (acc_clr),
            .result_we     (result_we),
            .calc_end      (calc_end),
            .busy          (busy),
            .state_o       (state_o)
        );
        assign obs[g] = {busy, lnc, ram_rd, cache_we, acc_ce, acc_clr, result_we, calc_end,
                         n_index, k_index, cache_wadr, state_o};
    end

    // Phase of cycle t after the start-sample cycle: 0 idle, 1 load, 2 flush_l, 3 compute, 4 flush_c, 5 write, 6 done.
    function automatic int ph(int t, int n, int l);
        int c;
        if (t <= 0) return 0;
        if (t <= n) return 1;
        if (t <= n + l) return 2;
        c = t - (n + l + 1);
        if (c >= n * (n + l + 1)) return 6;
        c = c % (n + l + 1);
        return c < n ? 3 : c < n + l ? 4 : 5;
    endfunction

    function automatic int nidx(int t, int n, int l);
        int p;
        p = ph(t, n, l);
        return p == 1 ? t - 1 : p == 3 ? (t - (n + l + 1)) % (n + l + 1) : 0;
    endfunction

    function automatic int kidx(int t, int n, int l);
        int p;
        p = ph(t, n, l);
        return p == 6 ? n - 1 : (p >= 3 && p <= 5) ? (t - (n + l + 1)) / (n + l + 1) : 0;
    endfunction

    function automatic int dn(int n, int l);
        return 1 + n + l + n * (n + l + 1);
    endfunction

    function automatic logic [2:0] st_of(int p);
        case (p)
            1:       return S_LOAD;
            2:       return S_FLUSH_L;
            3:       return S_COMPUTE;
            4:       return S_FLUSH_C;
            5:       return S_WRITE;
            6:       return S_DONE;
            default: return S_IDLE;
        endcase
    endfunction

    function automatic obs_t model(int t, int n, int l, bit kill);
        obs_t e;
        int   p;
        p           = ph(t, n, l);
        e.busy      = p >= 1 && p <= 5;
        e.lnc       = !(p >= 3 && p <= 5);
        e.ram_rd    = p == 1;
        e.cache_we  = ph(t - l, n, l) == 1;
        e.acc_ce    = ph(t - l, n, l) == 3;
        e.acc_clr   = p == 5 || kill;
        e.result_we = p == 5 && !kill;
        e.calc_end  = p == 6;
        e.n_index   = 12'(nidx(t, n, l));
        e.k_index   = 12'(kidx(t, n, l));
        e.wadr      = 12'(nidx(t - l, n, l));
        e.st        = st_of(p);
        return e;
    endfunction

    task automatic chk(string tag, obs_t got, obs_t exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(int t, int n, bit kill);
        for (int g = 0; g < 2; g++)
            chk($sformatf("L%0d_N%0d_t%0d", lat[g], n, t), obs[g],
                model(t, n, lat[g], kill && ph(t, n, lat[g]) != 0));
    endtask

    task automatic check_idle(string tag);
        for (int g = 0; g < 2; g++) chk($sformatf("%s_L%0d", tag, lat[g]), obs[g], model(0, 1, 1, 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ta: abort/disable cycle (0 = none); tr: async reset cycle (0 = none).
    task automatic run(int n, int ta, bit by_en, int tr);
        int dmax, w;
        dmax = dn(n, 3);
        w    = $urandom_range(0, 3);
        tick();
        sample_num = 12'(n);
        start      = 1;
        enable     = 1;
        abort      = 0;
        result_ack = 0;
        @(negedge clk);
        check_idle("prestart");
        for (int t = 1; t <= dmax + w; t++) begin
            tick();
            start      = 1'($urandom);
            sample_num = 12'($urandom_range(0, 15));
            abort      = t == ta && !by_en;
            enable     = !(t == ta && by_en);
            result_ack = t == dmax + w;
            if (t == tr) begin
                start = 0;
                #2 n_Reset = 0;
                #1 check_idle("async_reset");
                @(negedge clk);
                n_Reset = 1;
                break;
            end
            @(negedge clk);
            check_all(t, n, t == ta);
            if (t == ta) break;
        end
        tick();
        start      = 0;
        abort      = 0;
        enable     = 1;
        result_ack = 0;
        @(negedge clk);
        check_idle("after_run");
    endtask

    initial begin
        int n, ta;
        #1 n_Reset = 0;
        #1 check_idle("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_Reset = 1;
        run(4, 0, 0, 0);
        run(1, 0, 0, 0);
        run(4, 19, 0, 0);
        run(8, 0, 0, 0);
        run(3, 7, 1, 0);
        run(4, 0, 0, 10);
        tick();
        sample_num = '0;
        start      = 1;
        repeat (3) begin
            tick();
            @(negedge clk);
            check_idle("zero_n");
        end
        sample_num = 12'd5;
        enable     = 0;
        repeat (2) begin
            tick();
            @(negedge clk);
            check_idle("disabled");
        end
        start  = 0;
        enable = 1;
        repeat (8) begin
            n  = $urandom_range(1, 6);
            ta = $urandom_range(0, 1) != 0 ? $urandom_range(1, dn(n, 3) - 1) : 0;
            run(n, ta, 1'($urandom), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
